// File: rtl/sync_pulse_generator.sv
// Periodic reference pulse generator for the DIO line, with an armable trigger
// that fires a programmable number of samples before the end of a period.
`timescale 1ns / 1ps

module sync_pulse_generator #(
    parameter int PERIOD_WIDTH      = 32,
    parameter int PULSE_WIDTH_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         enable,
    input  logic [PERIOD_WIDTH-1:0]      period,
    input  logic [PULSE_WIDTH_WIDTH-1:0] pulse_width,
    input  logic [PERIOD_WIDTH-1:0]      trigger_presamples,
    input  logic                         trigger_arm,
    input  logic                         trigger_reset,
    output logic                         sync_out,
    output logic                         trigger,
    output logic                         trigger_armed,
    output logic [PERIOD_WIDTH-1:0]      period_counter,
    output logic [PERIOD_WIDTH-1:0]      cycle_count
);

    typedef enum logic [1:0] {
        TRIG_DISARMED = 2'd0,
        TRIG_PENDING  = 2'd1,
        TRIG_ARMED    = 2'd2,
        TRIG_FIRED    = 2'd3
    } trig_state_t;

    localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] TWO = PERIOD_WIDTH'(2);

    logic                    idle;
    logic                    running;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] cycles;
    logic [PERIOD_WIDTH-1:0] per_act;
    logic [PERIOD_WIDTH-1:0] pw_act;
    logic [PERIOD_WIDTH-1:0] pre_act;
    logic [PERIOD_WIDTH-1:0] per_next;
    logic [PERIOD_WIDTH-1:0] per_next_m1;
    logic [PERIOD_WIDTH-1:0] pw_ext;
    logic [PERIOD_WIDTH-1:0] pw_next;
    logic [PERIOD_WIDTH:0]   fire_diff;
    logic [PERIOD_WIDTH-1:0] fire_point;
    logic                    wrap;
    logic                    load_shadow;
    logic                    at_fire;
    trig_state_t             state;
    trig_state_t             state_next;

    assign idle = !aresetn || !enable;

    // A wrap only exists once the shadows are valid, i.e. after the first running edge.
    assign wrap        = running && (cnt == per_act - ONE);
    assign load_shadow = !running || wrap;

    assign per_next    = (period < TWO) ? TWO : period;
    assign per_next_m1 = per_next - ONE;
    assign pw_ext      = PERIOD_WIDTH'(pulse_width);
    assign pw_next     = (pw_ext > per_next_m1) ? per_next_m1 : pw_ext;

    // The extra MSB is the borrow of per_act-1-pre_act: set means the
    // presample count reaches past the period start, so fire at cnt=0.
    assign fire_diff  = {1'b0, per_act} - {1'b0, pre_act} - {{PERIOD_WIDTH{1'b0}}, 1'b1};
    assign fire_point = fire_diff[PERIOD_WIDTH] ? '0 : fire_diff[PERIOD_WIDTH-1:0];
    assign at_fire    = running && (cnt == fire_point);

    // NOTE: shadow registers carry no reset; they are always loaded on the
    // first running edge before anything reads them.
    always_ff @(posedge clk) begin
        if (!idle && load_shadow) begin
            per_act <= per_next;
            pw_act  <= pw_next;
            pre_act <= trigger_presamples;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (idle) begin
            running  <= 1'b0;
            cnt      <= '0;
            cycles   <= '0;
            sync_out <= 1'b0;
        end else begin
            running  <= 1'b1;
            sync_out <= running && (cnt < pw_act);
            if (!running || wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
            if (wrap) begin
                cycles <= cycles + ONE;
            end
        end
    end

    // NOTE: every variable gets its default before the case so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            TRIG_DISARMED: if (trigger_arm) state_next = TRIG_PENDING;
            TRIG_PENDING:  if (wrap)        state_next = TRIG_ARMED;
            TRIG_ARMED:    if (at_fire)     state_next = TRIG_FIRED;
            TRIG_FIRED:                     state_next = TRIG_FIRED;
            default:                        state_next = TRIG_DISARMED;
        endcase
        if (trigger_reset || idle) begin
            state_next = TRIG_DISARMED;
        end
    end

    // A disabled generator holds trigger high so it never blocks the AND tree.
    always_ff @(posedge clk) begin
        state         <= state_next;
        trigger       <= idle ? !enable : (state_next == TRIG_FIRED);
        trigger_armed <= (state_next == TRIG_ARMED) || (state_next == TRIG_FIRED);
    end

    assign period_counter = cnt;
    assign cycle_count    = cycles;

endmodule
